ft2_cmd_parser: RTL and testbench

- Sits directly downstream of the FT2232H byte-to-word read stage.
- Consumes its 32-bit big-endian words and the one-cycle word strobe that accompanies each word.
- Parses a framed command stream from the host PC: header word, then optional payload words.
- Issues register-write strobes to the scope control register bank, trigger pulses, and error reports. This is the host-to-FPGA control path.

---
 rtl/ft2_cmd_parser.sv | 227 ++++++++++++++++++++++
 tb/tb_ft2_cmd_parser.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft2_cmd_parser.sv
// ft2_cmd_parser
//   Host-to-FPGA control path. Parses the framed command stream coming out of
//   the FT2232H byte-to-word read stage and turns it into register writes,
//   software triggers and error reports.
//
//   Frame: header word {sync[31:24], opcode[23:16], addr[15:8], count[7:0]}
//   followed by `count` payload words for WRITE. Payload words are never
//   treated as headers.
//
//   Optional feature (macro CMD_CHECKSUM_EN): every WRITE ends with a check
//   word that must equal the XOR of the header and all payload words.
//
//   Ports
//     clk         system clock (same domain as the read stage)
//     rst_n       synchronous active-low reset
//     word_in     32-bit big-endian word, byte 0 in [31:24]
//     word_valid  one-cycle strobe qualifying word_in
//     reg_we      one-cycle register write strobe
//     reg_addr    register address, valid with reg_we
//     reg_wdata   register data, valid with reg_we
//     trig_pulse  one-cycle software trigger
//     trig_id     trigger selector, valid with trig_pulse
//     cmd_done    one-cycle pulse on successful command completion
//     err_stb     one-cycle error pulse
//     err_code    1 bad sync, 2 bad opcode, 3 timeout, 0 checksum; holds
//     busy        high while a command is in progress
//
//   All outputs are registered: one clk from word_valid to the strobe.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | waiting for a header word
//   PAYLOAD | WRITE in progress, consuming payload words
//   CHECK   | (CMD_CHECKSUM_EN only) waiting for the XOR check word

module ft2_cmd_parser #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned TO_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  output logic        reg_we,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        trig_pulse,
  output logic [7:0]  trig_id,
  output logic        cmd_done,
  output logic        err_stb,
  output logic [1:0]  err_code,
  output logic        busy
);

  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_TRIG  = 8'h02;

  localparam logic [1:0] ERR_SYNC    = 2'd1;
  localparam logic [1:0] ERR_OPCODE  = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Counter value at which the next idle cycle completes the timeout window.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

`ifdef CMD_CHECKSUM_EN
  localparam logic [1:0] ERR_CSUM = 2'd0;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PAYLOAD = 2'd1, ST_CHECK = 2'd2} state_t;
  logic [31:0] csum_q, csum_d;
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PAYLOAD = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       remaining_q, remaining_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic             we_d, trig_d, done_d, err_d;
  logic [7:0]       raddr_d, tid_d;
  logic [31:0]      wdata_d;
  logic [1:0]       ec_d;
  logic             timeout_hit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      to_cnt_q    <= '0;
      reg_we      <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      trig_pulse  <= 1'b0;
      trig_id     <= '0;
      cmd_done    <= 1'b0;
      err_stb     <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
`ifdef CMD_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      to_cnt_q    <= to_cnt_d;
      reg_we      <= we_d;
      reg_addr    <= raddr_d;
      reg_wdata   <= wdata_d;
      trig_pulse  <= trig_d;
      trig_id     <= tid_d;
      cmd_done    <= done_d;
      err_stb     <= err_d;
      err_code    <= ec_d;
      busy        <= (state_d != ST_IDLE);
`ifdef CMD_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign timeout_hit = (to_cnt_q == TO_LAST);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    to_cnt_d    = '0;            // cleared unless an idle PAYLOAD/CHECK cycle counts
    we_d        = 1'b0;
    raddr_d     = reg_addr;
    wdata_d     = reg_wdata;
    trig_d      = 1'b0;
    tid_d       = trig_id;
    done_d      = 1'b0;
    err_d       = 1'b0;
    ec_d        = err_code;
`ifdef CMD_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (word_valid) begin
          if (word_in[31:24] != SYNC_BYTE) begin
            err_d = 1'b1;
            ec_d  = ERR_SYNC;
          end else begin
            case (word_in[23:16])
              OP_NOP: done_d = 1'b1;
              OP_TRIG: begin
                trig_d = 1'b1;
                tid_d  = word_in[15:8];
                done_d = 1'b1;
              end
              OP_WRITE: begin
                addr_d      = word_in[15:8];
                remaining_d = word_in[7:0];
`ifdef CMD_CHECKSUM_EN
                csum_d      = word_in;
                state_d     = (word_in[7:0] == 8'd0) ? ST_CHECK : ST_PAYLOAD;
`else
                if (word_in[7:0] == 8'd0) done_d  = 1'b1;
                else                      state_d = ST_PAYLOAD;
`endif
              end
              default: begin
                err_d = 1'b1;
                ec_d  = ERR_OPCODE;
              end
            endcase
          end
        end
      end

      ST_PAYLOAD: begin
        // An arriving word wins over a timeout firing in the same cycle.
        if (word_valid) begin
          we_d        = 1'b1;
          raddr_d     = addr_q;
          wdata_d     = word_in;
          addr_d      = addr_q + 8'd1;
          remaining_d = remaining_q - 8'd1;
`ifdef CMD_CHECKSUM_EN
          csum_d      = csum_q ^ word_in;
          if (remaining_q == 8'd1) state_d = ST_CHECK;
`else
          if (remaining_q == 8'd1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
`endif
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          ec_d    = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end

`ifdef CMD_CHECKSUM_EN
      ST_CHECK: begin
        if (word_valid) begin
          if (word_in == csum_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
            ec_d  = ERR_CSUM;
          end
          state_d = ST_IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          ec_d    = ERR_TIMEOUT;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
`endif

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ft2_cmd_parser.sv
module tb_ft2_cmd_parser;

  localparam int TO = 50;
`ifdef CMD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] word_in = '0;
  logic        word_valid = 1'b0;
  logic        reg_we, trig_pulse, cmd_done, err_stb, busy;
  logic [7:0]  reg_addr, trig_id;
  logic [31:0] reg_wdata;
  logic [1:0]  err_code;

  int compared = 0;
  int failed   = 0;
  int cycle    = 0;

  always #5 clk = ~clk;

  ft2_cmd_parser #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .TO_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .word_in(word_in), .word_valid(word_valid),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .trig_pulse(trig_pulse), .trig_id(trig_id), .cmd_done(cmd_done),
    .err_stb(err_stb), .err_code(err_code), .busy(busy)
  );

  // ---------------- behavioural reference model ----------------
  bit          m_active, m_check;
  int          m_left, m_addr, m_silent;
  logic [31:0] m_csum;
  logic        m_we, m_tp, m_done, m_err, m_busy;
  logic [7:0]  m_addr_o, m_tid;
  logic [31:0] m_data;
  logic [1:0]  m_ec = 2'd0;

  task automatic model_edge(input bit rst, input bit wv, input logic [31:0] w);
    m_we = 0; m_tp = 0; m_done = 0; m_err = 0;
    if (!rst) begin
      m_active = 0; m_check = 0; m_ec = 0; m_addr_o = 0; m_data = 0; m_tid = 0;
    end else if (m_active) begin
      if (wv) begin
        m_silent = 0;
        if (m_check) begin
          if (w == m_csum) m_done = 1;
          else begin m_err = 1; m_ec = 2'd0; end
          m_active = 0;
        end else begin
          m_we = 1; m_addr_o = 8'(m_addr); m_data = w;
          m_addr = (m_addr + 1) % 256;
          m_left = m_left - 1;
          m_csum = m_csum ^ w;
          if (m_left == 0) begin
            if (CK) m_check = 1;
            else begin m_done = 1; m_active = 0; end
          end
        end
      end else begin
        m_silent = m_silent + 1;
        if (m_silent == TO) begin m_err = 1; m_ec = 2'd3; m_active = 0; end
      end
    end else if (wv) begin
      if (w[31:24] != 8'hA5) begin
        m_err = 1; m_ec = 2'd1;
      end else begin
        case (w[23:16])
          8'h00: m_done = 1;
          8'h02: begin m_tp = 1; m_tid = w[15:8]; m_done = 1; end
          8'h01: begin
            m_left = int'(w[7:0]); m_addr = int'(w[15:8]);
            m_csum = w; m_silent = 0; m_check = 0;
            if (m_left == 0) begin
              if (CK) begin m_active = 1; m_check = 1; end
              else m_done = 1;
            end else m_active = 1;
          end
          default: begin m_err = 1; m_ec = 2'd2; end
        endcase
      end
    end
    m_busy = m_active;
  endtask

  task automatic check_model();
    compared++;
    if (reg_we !== m_we || trig_pulse !== m_tp || cmd_done !== m_done ||
        err_stb !== m_err || busy !== m_busy || err_code !== m_ec ||
        (m_we && (reg_addr !== m_addr_o || reg_wdata !== m_data)) ||
        (m_tp && trig_id !== m_tid)) begin
      failed++;
      $display("FAIL model cyc %0d: got we=%b a=%h d=%h tp=%b id=%h dn=%b er=%b ec=%0d bz=%b, expected we=%b a=%h d=%h tp=%b id=%h dn=%b er=%b ec=%0d bz=%b",
               cycle, reg_we, reg_addr, reg_wdata, trig_pulse, trig_id, cmd_done, err_stb, err_code, busy,
               m_we, m_addr_o, m_data, m_tp, m_tid, m_done, m_err, m_ec, m_busy);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare.
  task automatic cyc(input bit wv, input logic [31:0] w, input bit rst);
    word_valid = wv; word_in = w; rst_n = rst;
    @(posedge clk);
    model_edge(rst, wv, w);
    cycle++;
    #1;
    check_model();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, $urandom, 1'b1);
  endtask

  task automatic gap();
    if ($urandom_range(0, 9) == 0) idle($urandom_range(TO - 5, TO + 5));
    else idle($urandom_range(0, 2));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wv;
    logic [31:0] w;
    logic        we;
    logic [7:0]  a;
    logic [31:0] d;
    logic        tp;
    logic [7:0]  tid;
    logic        done;
    logic        err;
    logic [1:0]  ec;
    logic        bz;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t v(logic wv, logic [31:0] w, logic we, logic [7:0] a, logic [31:0] d,
                             logic tp, logic [7:0] tid, logic done, logic err, logic [1:0] ec, logic bz);
    vec_t r;
    r.wv = wv; r.w = w; r.we = we; r.a = a; r.d = d; r.tp = tp; r.tid = tid;
    r.done = done; r.err = err; r.ec = ec; r.bz = bz;
    return r;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hdr, w, csum;
    int cnt, sent;
    logic [7:0] a;

`ifdef CMD_CHECKSUM_EN
    tv.push_back(v(1, 32'hA5090000, 0, 8'h00, 0, 0, 0, 0, 1, 2, 0));
    tv.push_back(v(1, 32'hA5010302, 0, 8'h00, 0, 0, 0, 0, 0, 2, 1));
    tv.push_back(v(1, 32'hDEADBEEF, 1, 8'h03, 32'hDEADBEEF, 0, 0, 0, 0, 2, 1));
    tv.push_back(v(1, 32'h12345678, 1, 8'h04, 32'h12345678, 0, 0, 0, 0, 2, 1));
    tv.push_back(v(1, 32'hA5010302 ^ 32'hDEADBEEF ^ 32'h12345678, 0, 0, 0, 0, 0, 1, 0, 2, 0));
    tv.push_back(v(1, 32'hA5010000, 0, 0, 0, 0, 0, 0, 0, 2, 1));
    tv.push_back(v(1, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 0, 0));
    tv.push_back(v(1, 32'hA5010000, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(v(1, 32'hA5010000, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(1, 32'hA5020700, 0, 0, 0, 1, 8'h07, 1, 0, 0, 0));
`else
    tv.push_back(v(1, 32'hA5010302, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(v(1, 32'hDEADBEEF, 1, 8'h03, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1));
    tv.push_back(v(1, 32'h12345678, 1, 8'h04, 32'h12345678, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tv.push_back(v(1, 32'hA501FF02, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    tv.push_back(v(1, 32'h11111111, 1, 8'hFF, 32'h11111111, 0, 0, 0, 0, 0, 1));
    tv.push_back(v(1, 32'hA5A5A5A5, 1, 8'h00, 32'hA5A5A5A5, 0, 0, 1, 0, 0, 0));
    tv.push_back(v(1, 32'hA5020700, 0, 0, 0, 1, 8'h07, 1, 0, 0, 0));
    tv.push_back(v(1, 32'h11010101, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tv.push_back(v(1, 32'hA5090000, 0, 0, 0, 0, 0, 0, 1, 2, 0));
    tv.push_back(v(0, 32'h00000000, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    tv.push_back(v(1, 32'hA5010000, 0, 0, 0, 0, 0, 1, 0, 2, 0));
    tv.push_back(v(1, 32'h00011234, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    tv.push_back(v(1, 32'hA5000000, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    tv.push_back(v(1, 32'hA5FF0000, 0, 0, 0, 0, 0, 0, 1, 2, 0));
`endif

    // reset state
    cyc(1'b0, 32'h0, 1'b0);
    cyc(1'b1, 32'hA5020900, 1'b0);
    chk("rst reg_we", 32'(reg_we), 0);
    chk("rst trig_pulse", 32'(trig_pulse), 0);
    chk("rst cmd_done", 32'(cmd_done), 0);
    chk("rst err_stb", 32'(err_stb), 0);
    chk("rst err_code", 32'(err_code), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst reg_addr", 32'(reg_addr), 0);
    chk("rst reg_wdata", reg_wdata, 0);
    chk("rst trig_id", 32'(trig_id), 0);

    // table
    foreach (tv[i]) begin
      cyc(tv[i].wv, tv[i].w, 1'b1);
      compared++;
      if (reg_we !== tv[i].we || trig_pulse !== tv[i].tp || cmd_done !== tv[i].done ||
          err_stb !== tv[i].err || err_code !== tv[i].ec || busy !== tv[i].bz ||
          (tv[i].we && (reg_addr !== tv[i].a || reg_wdata !== tv[i].d)) ||
          (tv[i].tp && trig_id !== tv[i].tid)) begin
        failed++;
        $display("FAIL vec %0d: got we=%b a=%h d=%h tp=%b id=%h dn=%b er=%b ec=%0d bz=%b, expected we=%b a=%h d=%h tp=%b id=%h dn=%b er=%b ec=%0d bz=%b",
                 i, reg_we, reg_addr, reg_wdata, trig_pulse, trig_id, cmd_done, err_stb, err_code, busy,
                 tv[i].we, tv[i].a, tv[i].d, tv[i].tp, tv[i].tid, tv[i].done, tv[i].err, tv[i].ec, tv[i].bz);
      end
    end

    // timeout: fires exactly TO cycles after the last payload word
    cyc(1'b1, 32'hA5011004, 1'b1);
    cyc(1'b1, 32'h0BADF00D, 1'b1);
    chk("to payload we", 32'(reg_we), 1);
    for (int k = 1; k <= TO; k++) begin
      cyc(1'b0, 32'h0, 1'b1);
      if (k == TO - 1) chk("to not early", 32'(err_stb), 0);
    end
    chk("to err_stb", 32'(err_stb), 1);
    chk("to err_code", 32'(err_code), 3);
    chk("to busy", 32'(busy), 0);
    cyc(1'b1, 32'hA5000000, 1'b1);
    chk("to next hdr done", 32'(cmd_done), 1);

    // word arriving on the timeout cycle wins
    cyc(1'b1, 32'hA5013001, 1'b1);
    idle(TO - 1);
    cyc(1'b1, 32'h5555AAAA, 1'b1);
    chk("prio we", 32'(reg_we), 1);
    chk("prio no err", 32'(err_stb), 0);
    chk("prio addr", 32'(reg_addr), 32'h30);
    if (CK) cyc(1'b1, 32'hA5013001 ^ 32'h5555AAAA, 1'b1);

    // reset mid-command
    cyc(1'b1, 32'hA5012003, 1'b1);
    cyc(1'b1, 32'hCAFEF00D, 1'b1);
    chk("rstmid we", 32'(reg_we), 1);
    chk("rstmid addr", 32'(reg_addr), 32'h20);
    cyc(1'b1, 32'h12121212, 1'b0);
    chk("rstmid no we", 32'(reg_we), 0);
    chk("rstmid busy", 32'(busy), 0);
    cyc(1'b1, 32'hA5000000, 1'b1);
    chk("rstmid nop done", 32'(cmd_done), 1);
    chk("rstmid nop no we", 32'(reg_we), 0);

    // random command stream against the model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 11))
        0: begin
          w = $urandom;
          if (w[31:24] == 8'hA5) w[31:24] = 8'h5A;
          cyc(1'b1, w, 1'b1);
        end
        1: cyc(1'b1, {8'hA5, 8'($urandom_range(3, 255)), 16'($urandom)}, 1'b1);
        2: cyc(1'b1, {8'hA5, 8'h02, 16'($urandom)}, 1'b1);
        3: cyc(1'b1, {8'hA5, 8'h00, 16'($urandom)}, 1'b1);
        4: cyc(1'b0, 32'h0, 1'b0);
        default: begin
          cnt = $urandom_range(0, 5);
          a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(253, 255)) : 8'($urandom);
          hdr = {8'hA5, 8'h01, a, 8'(cnt)};
          csum = hdr;
          cyc(1'b1, hdr, 1'b1);
          sent = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, cnt)) : cnt;
          for (int i = 0; i < sent; i++) begin
            gap();
            w = $urandom;
            if ($urandom_range(0, 3) == 0) w[31:24] = 8'hA5;
            csum = csum ^ w;
            cyc(1'b1, w, 1'b1);
          end
          if (CK && sent == cnt) begin
            gap();
            cyc(1'b1, ($urandom_range(0, 2) == 0) ? (csum ^ 32'h0000_0100) : csum, 1'b1);
          end
        end
      endcase
      idle($urandom_range(0, 2));
    end
    idle(TO + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
